// File: rtl/dcache_mshr_if.sv
// ---------------------------------------------------------------------------
// dcache_mshr_if
//
// Bundles every signal of the data-cache miss handler except clock and reset:
//   LSU miss side  : miss_valid, miss_addr, miss_is_store, miss_st_size,
//                    miss_st_data -> miss_ready
//   memory side    : proc2mem_command, proc2mem_addr <- mem2proc_transaction_tag,
//                    mem2proc_data, mem2proc_data_tag
//   dcache fill    : fill_grant -> mshr2Dcache_wr, mshr2Dcache_mem_block,
//                    mshr2Dcache_addr, mshr2Dcache_is_store,
//                    mshr2Dcache_st_size, mshr2Dcache_st_data
//   status         : mshr_full
//
// Modports:
//   slave  - the MSHR file itself (consumes misses, produces requests/fills)
//   master - the surrounding LSU / memory / dcache arbiter environment
// ---------------------------------------------------------------------------
interface dcache_mshr_if;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_is_store;
    logic [1:0]  miss_st_size;
    logic [31:0] miss_st_data;
    logic        miss_ready;

    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;

    logic        fill_grant;
    logic        mshr2Dcache_wr;
    logic [63:0] mshr2Dcache_mem_block;
    logic [31:0] mshr2Dcache_addr;
    logic        mshr2Dcache_is_store;
    logic [1:0]  mshr2Dcache_st_size;
    logic [31:0] mshr2Dcache_st_data;

    logic        mshr_full;

    modport slave (
        input  miss_valid, miss_addr, miss_is_store, miss_st_size, miss_st_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  fill_grant,
        output miss_ready, proc2mem_command, proc2mem_addr,
        output mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr,
        output mshr2Dcache_is_store, mshr2Dcache_st_size, mshr2Dcache_st_data,
        output mshr_full
    );

    modport master (
        output miss_valid, miss_addr, miss_is_store, miss_st_size, miss_st_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output fill_grant,
        input  miss_ready, proc2mem_command, proc2mem_addr,
        input  mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr,
        input  mshr2Dcache_is_store, mshr2Dcache_st_size, mshr2Dcache_st_data,
        input  mshr_full
    );
endinterface

// File: rtl/dcache_mshr.sv
// ---------------------------------------------------------------------------
// dcache_mshr
//
// Miss Status Holding Register file on the data-cache fill path. Accepts load
// and store misses, issues block-aligned MEM_LOAD requests, matches tagged
// memory responses back to entries and presents the filled block (with any
// pending store) on the dcache fill port.
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset
//   bus   - dcache_mshr_if.slave (miss input, memory request/response,
//           dcache fill output, mshr_full)
//
// Parameter:
//   N_MSHR - number of outstanding block misses (power of two, >= 2)
//
// Memory command encoding: MEM_NONE = 2'd0, MEM_LOAD = 2'd1.
//
// Optional feature macro: MSHR_FILL_BYPASS_EN
//   defined   - a response hitting a WAITING entry while no entry is READY is
//               forwarded to the fill outputs in the same cycle; if granted the
//               entry retires straight from WAITING.
//   undefined - fills start no earlier than the cycle after the response.
// ---------------------------------------------------------------------------
module dcache_mshr #(
    parameter int N_MSHR = 4
) (
    input  logic         clock,
    input  logic         reset,
    dcache_mshr_if.slave bus
);
    localparam int         IW       = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    typedef enum logic [1:0] {
        ST_INVALID = 2'd0,
        ST_PENDING = 2'd1,
        ST_WAITING = 2'd2,
        ST_READY   = 2'd3
    } ent_state_e;

    ent_state_e  state_q    [N_MSHR];
    ent_state_e  state_d    [N_MSHR];
    logic [28:0] blk_q      [N_MSHR];
    logic [28:0] blk_d      [N_MSHR];
    logic [3:0]  tag_q      [N_MSHR];
    logic [3:0]  tag_d      [N_MSHR];
    logic [63:0] data_q     [N_MSHR];
    logic [63:0] data_d     [N_MSHR];
    logic        is_store_q [N_MSHR];
    logic        is_store_d [N_MSHR];
    logic [1:0]  st_size_q  [N_MSHR];
    logic [1:0]  st_size_d  [N_MSHR];
    logic [31:0] st_data_q  [N_MSHR];
    logic [31:0] st_data_d  [N_MSHR];
    logic [2:0]  off_q      [N_MSHR];
    logic [2:0]  off_d      [N_MSHR];

    logic          any_invalid, live_match, pend_found, ready_found, resp_hit;
    logic [IW-1:0] alloc_idx, pend_idx, ready_idx, resp_idx, fill_idx;
    logic          do_alloc, bypass, fill_valid;

    // Priority scans. Walking from the top index down leaves the lowest
    // matching index in each *_idx.
    always_comb begin : scan
        any_invalid = 1'b0;
        live_match  = 1'b0;
        pend_found  = 1'b0;
        ready_found = 1'b0;
        resp_hit    = 1'b0;
        alloc_idx   = '0;
        pend_idx    = '0;
        ready_idx   = '0;
        resp_idx    = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (state_q[i] == ST_INVALID) begin
                any_invalid = 1'b1;
                alloc_idx   = IW'(i);
            end else if (blk_q[i] == bus.miss_addr[31:3]) begin
                live_match = 1'b1;
            end
            if (state_q[i] == ST_PENDING) begin
                pend_found = 1'b1;
                pend_idx   = IW'(i);
            end
            if (state_q[i] == ST_READY) begin
                ready_found = 1'b1;
                ready_idx   = IW'(i);
            end
            // Tags are unique among WAITING entries, so at most one hits.
            if (state_q[i] == ST_WAITING && bus.mem2proc_data_tag != 4'd0 &&
                tag_q[i] == bus.mem2proc_data_tag) begin
                resp_hit = 1'b1;
                resp_idx = IW'(i);
            end
        end
    end

`ifdef MSHR_FILL_BYPASS_EN
    assign bypass = !ready_found && resp_hit;
`else
    assign bypass = 1'b0;
`endif

    // A live block match absorbs loads and blocks stores; otherwise a free
    // entry is needed. Entries freed this cycle are not counted as free.
    assign do_alloc   = bus.miss_valid && !live_match && any_invalid;
    assign fill_valid = ready_found || bypass;
    assign fill_idx   = ready_found ? ready_idx : resp_idx;

    always_comb begin : outputs
        bus.miss_ready       = !bus.miss_valid ||
                               (live_match ? !bus.miss_is_store : any_invalid);
        bus.mshr_full        = !any_invalid;
        bus.proc2mem_command = pend_found ? MEM_LOAD : MEM_NONE;
        bus.proc2mem_addr    = pend_found ? {blk_q[pend_idx], 3'b000} : 32'd0;

        bus.mshr2Dcache_wr        = fill_valid;
        bus.mshr2Dcache_mem_block = 64'd0;
        bus.mshr2Dcache_addr      = 32'd0;
        bus.mshr2Dcache_is_store  = 1'b0;
        bus.mshr2Dcache_st_size   = 2'd0;
        bus.mshr2Dcache_st_data   = 32'd0;
        if (fill_valid) begin
            bus.mshr2Dcache_mem_block = bypass ? bus.mem2proc_data : data_q[fill_idx];
            // Stores keep their byte offset so the cache can merge the data.
            bus.mshr2Dcache_addr      = is_store_q[fill_idx] ?
                                        {blk_q[fill_idx], off_q[fill_idx]} :
                                        {blk_q[fill_idx], 3'b000};
            bus.mshr2Dcache_is_store  = is_store_q[fill_idx];
            bus.mshr2Dcache_st_size   = st_size_q[fill_idx];
            bus.mshr2Dcache_st_data   = st_data_q[fill_idx];
        end
    end

    // Each transition below fires from a distinct current state, so the
    // simultaneous allocate / accept / response / retire cases never collide.
    always_comb begin : next_state
        state_d    = state_q;
        blk_d      = blk_q;
        tag_d      = tag_q;
        data_d     = data_q;
        is_store_d = is_store_q;
        st_size_d  = st_size_q;
        st_data_d  = st_data_q;
        off_d      = off_q;
        for (int i = 0; i < N_MSHR; i++) begin
            case (state_q[i])
                ST_INVALID: begin
                    if (do_alloc && alloc_idx == IW'(i)) begin
                        state_d[i]    = ST_PENDING;
                        blk_d[i]      = bus.miss_addr[31:3];
                        off_d[i]      = bus.miss_addr[2:0];
                        tag_d[i]      = 4'd0;
                        data_d[i]     = 64'd0;
                        is_store_d[i] = bus.miss_is_store;
                        st_size_d[i]  = bus.miss_is_store ? bus.miss_st_size : 2'd0;
                        st_data_d[i]  = bus.miss_is_store ? bus.miss_st_data : 32'd0;
                    end
                end
                ST_PENDING: begin
                    // Tag 0 means memory refused; the entry simply re-issues.
                    if (pend_idx == IW'(i) && bus.mem2proc_transaction_tag != 4'd0) begin
                        state_d[i] = ST_WAITING;
                        tag_d[i]   = bus.mem2proc_transaction_tag;
                    end
                end
                ST_WAITING: begin
                    if (resp_hit && resp_idx == IW'(i)) begin
                        data_d[i]  = bus.mem2proc_data;
                        state_d[i] = (bypass && bus.fill_grant) ? ST_INVALID : ST_READY;
                    end
                end
                default: begin
                    if (ready_idx == IW'(i) && bus.fill_grant) begin
                        state_d[i] = ST_INVALID;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_MSHR; i++) begin
                state_q[i]    <= ST_INVALID;
                blk_q[i]      <= 29'd0;
                tag_q[i]      <= 4'd0;
                data_q[i]     <= 64'd0;
                is_store_q[i] <= 1'b0;
                st_size_q[i]  <= 2'd0;
                st_data_q[i]  <= 32'd0;
                off_q[i]      <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            is_store_q <= is_store_d;
            st_size_q  <= st_size_d;
            st_data_q  <= st_data_d;
            off_q      <= off_d;
        end
    end
endmodule

// File: tb/tb_dcache_mshr.sv
// ---------------------------------------------------------------------------
// tb_dcache_mshr
//
// Directed scenarios for the miss handler followed by a randomized run that
// is checked every cycle against a slot-based reference model of the miss
// file (free / requesting / in memory / holding data).
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 time
// unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_dcache_mshr;
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_mshr_if bus ();
    dcache_mshr #(.N_MSHR(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Reference model: slot state 0 free, 1 needs request, 2 in memory,
    // 3 holds data.
    int          m_st    [4];
    logic [28:0] m_blk   [4];
    logic [31:0] m_faddr [4];
    logic [3:0]  m_tag   [4];
    logic [63:0] m_data  [4];
    logic        m_store [4];
    logic [1:0]  m_size  [4];
    logic [31:0] m_sdata [4];

    logic        e_ready, e_full, e_wr, e_store;
    logic [1:0]  e_cmd, e_size;
    logic [31:0] e_paddr, e_faddr, e_sdata;
    logic [63:0] e_block;
    int          r_slot, s_slot, f_slot, a_slot;
    bit          f_bypass;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_st[i] = 0;
    endfunction

    function automatic void model_eval();
        int  free_cnt;
        bit  match;
        free_cnt = 0;
        match    = 0;
        r_slot = -1; s_slot = -1; f_slot = -1; a_slot = -1; f_bypass = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_st[i] == 0) begin
                free_cnt++;
                if (a_slot < 0) a_slot = i;
            end else if (m_blk[i] == bus.miss_addr[31:3]) begin
                match = 1;
            end
            if (m_st[i] == 1 && r_slot < 0) r_slot = i;
            if (m_st[i] == 3 && f_slot < 0) f_slot = i;
            if (m_st[i] == 2 && bus.mem2proc_data_tag != 4'd0 && m_tag[i] == bus.mem2proc_data_tag)
                s_slot = i;
        end
        e_full  = (free_cnt == 0);
        e_ready = !bus.miss_valid || (match ? !bus.miss_is_store : (free_cnt > 0));
        if (!bus.miss_valid || match) a_slot = -1;
        e_cmd   = MEM_NONE;
        e_paddr = 32'd0;
        if (r_slot >= 0) begin
            e_cmd   = MEM_LOAD;
            e_paddr = {m_blk[r_slot], 3'b000};
        end
`ifdef MSHR_FILL_BYPASS_EN
        if (f_slot < 0 && s_slot >= 0) begin
            f_slot   = s_slot;
            f_bypass = 1;
        end
`endif
        e_wr = (f_slot >= 0);
        e_block = 64'd0; e_faddr = 32'd0; e_store = 1'b0; e_size = 2'd0; e_sdata = 32'd0;
        if (e_wr) begin
            e_block = f_bypass ? bus.mem2proc_data : m_data[f_slot];
            e_faddr = m_faddr[f_slot];
            e_store = m_store[f_slot];
            e_size  = m_size[f_slot];
            e_sdata = m_sdata[f_slot];
        end
    endfunction

    function automatic void model_step();
        model_eval();
        if (r_slot >= 0 && bus.mem2proc_transaction_tag != 4'd0) begin
            m_st[r_slot]  = 2;
            m_tag[r_slot] = bus.mem2proc_transaction_tag;
        end
        if (s_slot >= 0) begin
            m_data[s_slot] = bus.mem2proc_data;
            m_st[s_slot]   = (f_bypass && bus.fill_grant) ? 0 : 3;
        end
        if (f_slot >= 0 && !f_bypass && bus.fill_grant) m_st[f_slot] = 0;
        if (a_slot >= 0) begin
            m_st[a_slot]    = 1;
            m_blk[a_slot]   = bus.miss_addr[31:3];
            m_faddr[a_slot] = bus.miss_is_store ? bus.miss_addr : {bus.miss_addr[31:3], 3'b000};
            m_store[a_slot] = bus.miss_is_store;
            m_size[a_slot]  = bus.miss_is_store ? bus.miss_st_size : 2'd0;
            m_sdata[a_slot] = bus.miss_is_store ? bus.miss_st_data : 32'd0;
        end
    endfunction

    function automatic bit tag_busy(input logic [3:0] t);
        for (int i = 0; i < 4; i++)
            if (m_st[i] == 2 && m_tag[i] == t) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] fresh_tag();
        logic [3:0] t;
        for (int k = 0; k < 16; k++) begin
            t = 4'($urandom_range(1, 15));
            if (!tag_busy(t)) return t;
        end
        for (int k = 1; k < 16; k++) begin
            t = 4'(k);
            if (!tag_busy(t)) return t;
        end
        return 4'd0;
    endfunction

    task automatic idle();
        bus.miss_valid = 0; bus.miss_addr = 0; bus.miss_is_store = 0;
        bus.miss_st_size = 0; bus.miss_st_data = 0;
        bus.mem2proc_transaction_tag = 0; bus.mem2proc_data = 0;
        bus.mem2proc_data_tag = 0; bus.fill_grant = 0;
    endtask

    task automatic miss(input logic [31:0] a, input logic st, input logic [1:0] sz, input logic [31:0] d);
        bus.miss_valid = 1; bus.miss_addr = a; bus.miss_is_store = st;
        bus.miss_st_size = sz; bus.miss_st_data = d;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #3;
        total++; if (bus.mshr2Dcache_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", bus.mshr2Dcache_wr); end
        total++; if (bus.proc2mem_command !== MEM_NONE) begin bad++; $display("FAIL rst_cmd got=%0d exp=0", bus.proc2mem_command); end
        total++; if (bus.mshr_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.mshr_full); end
        total++; if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL rst_miss_ready got=%b exp=1", bus.miss_ready); end
        total++; if (bus.proc2mem_addr !== 32'd0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", bus.proc2mem_addr); end
        total++; if (bus.mshr2Dcache_addr !== 32'd0 || bus.mshr2Dcache_mem_block !== 64'd0) begin bad++; $display("FAIL rst_fill_data got=%h/%h exp=0", bus.mshr2Dcache_addr, bus.mshr2Dcache_mem_block); end
        @(negedge clock);
        reset = 0;
        model_reset();
        @(posedge clock);
        #1;
        $display("test_reset: outputs at reset values");
    endtask

    task automatic test_basic();
        idle(); miss(32'h1004, 0, 2'd0, 0); #1;
        total++; if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", bus.miss_ready); end
        total++; if (bus.proc2mem_command !== MEM_NONE) begin bad++; $display("FAIL basic_early_cmd got=%0d exp=0", bus.proc2mem_command); end
        tick();
        idle(); bus.mem2proc_transaction_tag = 4'd3; #1;
        total++; if (bus.proc2mem_command !== MEM_LOAD || bus.proc2mem_addr !== 32'h1000) begin bad++; $display("FAIL basic_req got=%0d/%h exp=1/00001000", bus.proc2mem_command, bus.proc2mem_addr); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd3; bus.mem2proc_data = 64'hDEADBEEF_CAFEF00D; bus.fill_grant = 1; #1;
`ifdef MSHR_FILL_BYPASS_EN
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_mem_block !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL basic_bypass got=%b/%h", bus.mshr2Dcache_wr, bus.mshr2Dcache_mem_block); end
`else
        total++; if (bus.mshr2Dcache_wr !== 1'b0) begin bad++; $display("FAIL basic_fill_early got=%b exp=0", bus.mshr2Dcache_wr); end
`endif
        tick();
        idle(); bus.fill_grant = 1; #1;
`ifndef MSHR_FILL_BYPASS_EN
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_mem_block !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL basic_fill got=%b/%h exp=1/deadbeefcafef00d", bus.mshr2Dcache_wr, bus.mshr2Dcache_mem_block); end
        total++; if (bus.mshr2Dcache_addr !== 32'h1000 || bus.mshr2Dcache_is_store !== 1'b0) begin bad++; $display("FAIL basic_fill_addr got=%h/%b exp=00001000/0", bus.mshr2Dcache_addr, bus.mshr2Dcache_is_store); end
`endif
        tick();
        idle(); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0 || bus.mshr_full !== 1'b0) begin bad++; $display("FAIL basic_freed got=%b/%b exp=0/0", bus.mshr2Dcache_wr, bus.mshr_full); end
        $display("test_basic: load 0x1004 tag 3 filled block deadbeefcafef00d");
    endtask

    task automatic test_coalesce();
        int fills;
        idle(); miss(32'h2000, 0, 2'd0, 0); tick();
        idle(); bus.mem2proc_transaction_tag = 4'd4; #1;
        total++; if (bus.proc2mem_command !== MEM_LOAD || bus.proc2mem_addr !== 32'h2000) begin bad++; $display("FAIL coal_req got=%0d/%h exp=1/00002000", bus.proc2mem_command, bus.proc2mem_addr); end
        tick();
        idle(); miss(32'h2004, 0, 2'd0, 0); #1;
        total++; if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL coal_ready got=%b exp=1", bus.miss_ready); end
        tick();
        idle(); #1;
        total++; if (bus.proc2mem_command !== MEM_NONE) begin bad++; $display("FAIL coal_second_req got=%0d exp=0", bus.proc2mem_command); end
        bus.mem2proc_data_tag = 4'd4; bus.mem2proc_data = 64'h1111_2222_3333_4444;
        tick();
        fills = 0;
        for (int k = 0; k < 4; k++) begin
            idle(); bus.fill_grant = 1; #1;
            if (bus.mshr2Dcache_wr === 1'b1) fills++;
            tick();
        end
        total++; if (fills !== 1) begin bad++; $display("FAIL coal_fill_count got=%0d exp=1", fills); end
        $display("test_coalesce: loads 0x2000/0x2004 shared one request, fills=%0d", fills);
    endtask

    task automatic test_store();
        idle(); miss(32'h3002, 1, 2'd0, 32'hAB); #1;
        total++; if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL st_ready got=%b exp=1", bus.miss_ready); end
        tick();
        idle(); miss(32'h3000, 1, 2'd2, 32'h1234); bus.mem2proc_transaction_tag = 4'd6; #1;
        total++; if (bus.miss_ready !== 1'b0) begin bad++; $display("FAIL st_second_ready got=%b exp=0", bus.miss_ready); end
        total++; if (bus.proc2mem_addr !== 32'h3000) begin bad++; $display("FAIL st_req_addr got=%h exp=00003000", bus.proc2mem_addr); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd6; bus.mem2proc_data = 64'h0123_4567_89AB_CDEF; tick();
        idle(); miss(32'h3000, 1, 2'd2, 32'h1234); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_is_store !== 1'b1) begin bad++; $display("FAIL st_fill got=%b/%b exp=1/1", bus.mshr2Dcache_wr, bus.mshr2Dcache_is_store); end
        total++; if (bus.mshr2Dcache_addr !== 32'h3002) begin bad++; $display("FAIL st_fill_addr got=%h exp=00003002", bus.mshr2Dcache_addr); end
        total++; if (bus.mshr2Dcache_st_size !== 2'd0 || bus.mshr2Dcache_st_data !== 32'hAB) begin bad++; $display("FAIL st_fill_fields got=%0d/%h exp=0/000000ab", bus.mshr2Dcache_st_size, bus.mshr2Dcache_st_data); end
        total++; if (bus.miss_ready !== 1'b0) begin bad++; $display("FAIL st_ready_ready_entry got=%b exp=0", bus.miss_ready); end
        tick();
        idle(); bus.fill_grant = 1; tick();
        idle(); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0 || bus.mshr_full !== 1'b0) begin bad++; $display("FAIL st_freed got=%b/%b exp=0/0", bus.mshr2Dcache_wr, bus.mshr_full); end
        $display("test_store: byte store 0x3002 data ab filled");
    endtask

    task automatic test_retry();
        idle(); miss(32'h4000, 0, 2'd0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); #1;
            total++; if (bus.proc2mem_command !== MEM_LOAD || bus.proc2mem_addr !== 32'h4000) begin bad++; $display("FAIL retry_req%0d got=%0d/%h exp=1/00004000", k, bus.proc2mem_command, bus.proc2mem_addr); end
            tick();
        end
        idle(); bus.mem2proc_transaction_tag = 4'd5; #1;
        total++; if (bus.proc2mem_command !== MEM_LOAD || bus.proc2mem_addr !== 32'h4000) begin bad++; $display("FAIL retry_accept got=%0d/%h exp=1/00004000", bus.proc2mem_command, bus.proc2mem_addr); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd9; #1;
        total++; if (bus.proc2mem_command !== MEM_NONE) begin bad++; $display("FAIL retry_waiting got=%0d exp=0", bus.proc2mem_command); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd5; bus.mem2proc_data = 64'h5555_AAAA_5555_AAAA; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0) begin bad++; $display("FAIL retry_spurious got=%b exp=0", bus.mshr2Dcache_wr); end
        tick();
        idle(); bus.fill_grant = 1; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_addr !== 32'h4000) begin bad++; $display("FAIL retry_fill got=%b/%h exp=1/00004000", bus.mshr2Dcache_wr, bus.mshr2Dcache_addr); end
        tick();
        $display("test_retry: 0x4000 retried 3 times, accepted with tag 5");
    endtask

    task automatic test_full();
        logic [3:0] tags [5];
        tags[0] = 0; tags[1] = 2; tags[2] = 1; tags[3] = 3; tags[4] = 4;
        for (int k = 0; k < 4; k++) begin
            idle(); miss(32'h5000 + 32'(k) * 32'h100, 0, 2'd0, 0);
            bus.mem2proc_transaction_tag = tags[k]; #1;
            total++; if (bus.mshr_full !== 1'b0 || bus.miss_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d got=%b/%b exp=0/1", k, bus.mshr_full, bus.miss_ready); end
            tick();
        end
        idle(); miss(32'h5400, 0, 2'd0, 0); bus.mem2proc_transaction_tag = tags[4]; #1;
        total++; if (bus.mshr_full !== 1'b1 || bus.miss_ready !== 1'b0) begin bad++; $display("FAIL full_fifth got=%b/%b exp=1/0", bus.mshr_full, bus.miss_ready); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd2; bus.mem2proc_data = 64'hA0; tick();
        idle(); bus.mem2proc_data_tag = 4'd1; bus.mem2proc_data = 64'hA1; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_addr !== 32'h5000) begin bad++; $display("FAIL full_first_ready got=%b/%h exp=1/00005000", bus.mshr2Dcache_wr, bus.mshr2Dcache_addr); end
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); #1;
            total++; if (bus.mshr2Dcache_addr !== 32'h5000 || bus.mshr2Dcache_mem_block !== 64'hA0) begin bad++; $display("FAIL full_hold%0d got=%h/%h exp=00005000/a0", k, bus.mshr2Dcache_addr, bus.mshr2Dcache_mem_block); end
            tick();
        end
        idle(); bus.fill_grant = 1; tick();
        idle(); bus.mem2proc_data_tag = 4'd3; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.mshr2Dcache_addr !== 32'h5100 || bus.mshr2Dcache_mem_block !== 64'hA1) begin bad++; $display("FAIL full_next got=%b/%h/%h exp=1/00005100/a1", bus.mshr2Dcache_wr, bus.mshr2Dcache_addr, bus.mshr2Dcache_mem_block); end
        tick();
        idle(); bus.mem2proc_data_tag = 4'd4; bus.fill_grant = 1; tick();
        for (int k = 0; k < 3; k++) begin idle(); bus.fill_grant = 1; tick(); end
        idle(); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0 || bus.mshr_full !== 1'b0) begin bad++; $display("FAIL full_drained got=%b/%b exp=0/0", bus.mshr2Dcache_wr, bus.mshr_full); end
        $display("test_full: four blocks outstanding, fill order 0x5000 then 0x5100");
    endtask

    task automatic test_reset_mid();
        idle(); miss(32'h6000, 0, 2'd0, 0); tick();
        idle(); miss(32'h6100, 0, 2'd0, 0); bus.mem2proc_transaction_tag = 4'd7; tick();
        idle(); miss(32'h6200, 0, 2'd0, 0); bus.mem2proc_transaction_tag = 4'd8; tick();
        idle(); miss(32'h6300, 0, 2'd0, 0); bus.mem2proc_transaction_tag = 4'd9; tick();
        idle(); bus.mem2proc_data_tag = 4'd9; tick();
        idle(); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b1 || bus.proc2mem_command !== MEM_LOAD || bus.mshr_full !== 1'b1) begin bad++; $display("FAIL rmid_before got=%b/%0d/%b exp=1/1/1", bus.mshr2Dcache_wr, bus.proc2mem_command, bus.mshr_full); end
        reset = 1; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0 || bus.proc2mem_command !== MEM_NONE || bus.mshr_full !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/0", bus.mshr2Dcache_wr, bus.proc2mem_command, bus.mshr_full); end
        total++; if (bus.mshr2Dcache_addr !== 32'd0 || bus.proc2mem_addr !== 32'd0 || bus.miss_ready !== 1'b1) begin bad++; $display("FAIL rmid_async_data got=%h/%h/%b exp=0/0/1", bus.mshr2Dcache_addr, bus.proc2mem_addr, bus.miss_ready); end
        @(negedge clock);
        reset = 0;
        model_reset();
        @(posedge clock); #1;
        idle(); bus.mem2proc_data_tag = 4'd7; bus.mem2proc_data = 64'hBAD; tick();
        idle(); bus.mem2proc_data_tag = 4'd8; #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0) begin bad++; $display("FAIL rmid_stale_resp got=%b exp=0", bus.mshr2Dcache_wr); end
        tick();
        idle(); #1;
        total++; if (bus.mshr2Dcache_wr !== 1'b0 || bus.proc2mem_command !== MEM_NONE) begin bad++; $display("FAIL rmid_after got=%b/%0d exp=0/0", bus.mshr2Dcache_wr, bus.proc2mem_command); end
        $display("test_reset_mid: reset dropped 4 live entries, stale tags 7/8 ignored");
    endtask

    task automatic test_random();
        logic [3:0] waiting [$];
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                miss(32'h8000 + 32'($urandom_range(0, 7)) * 8 + 32'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), $urandom);
            model_eval();
            if (r_slot >= 0 && $urandom_range(0, 9) < 7) bus.mem2proc_transaction_tag = fresh_tag();
            waiting.delete();
            for (int i = 0; i < 4; i++) if (m_st[i] == 2) waiting.push_back(m_tag[i]);
            if (waiting.size() > 0 && $urandom_range(0, 99) < 45)
                bus.mem2proc_data_tag = waiting[$urandom_range(0, waiting.size() - 1)];
            else if ($urandom_range(0, 9) == 0)
                bus.mem2proc_data_tag = fresh_tag();
            bus.mem2proc_data = {$urandom, $urandom};
            bus.fill_grant = ($urandom_range(0, 1) == 1);
            #1;
            model_eval();
            total++; if (bus.miss_ready !== e_ready) begin bad++; $display("FAIL rnd_miss_ready cyc=%0d got=%b exp=%b", c, bus.miss_ready, e_ready); end
            total++; if (bus.mshr_full !== e_full) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", c, bus.mshr_full, e_full); end
            total++; if (bus.proc2mem_command !== e_cmd) begin bad++; $display("FAIL rnd_cmd cyc=%0d got=%0d exp=%0d", c, bus.proc2mem_command, e_cmd); end
            if (e_cmd == MEM_LOAD) begin
                total++; if (bus.proc2mem_addr !== e_paddr) begin bad++; $display("FAIL rnd_paddr cyc=%0d got=%h exp=%h", c, bus.proc2mem_addr, e_paddr); end
            end
            total++; if (bus.mshr2Dcache_wr !== e_wr) begin bad++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", c, bus.mshr2Dcache_wr, e_wr); end
            if (e_wr) begin
                total++; if (bus.mshr2Dcache_mem_block !== e_block) begin bad++; $display("FAIL rnd_block cyc=%0d got=%h exp=%h", c, bus.mshr2Dcache_mem_block, e_block); end
                total++; if (bus.mshr2Dcache_addr !== e_faddr) begin bad++; $display("FAIL rnd_faddr cyc=%0d got=%h exp=%h", c, bus.mshr2Dcache_addr, e_faddr); end
                total++; if (bus.mshr2Dcache_is_store !== e_store) begin bad++; $display("FAIL rnd_is_store cyc=%0d got=%b exp=%b", c, bus.mshr2Dcache_is_store, e_store); end
                if (e_store) begin
                    total++; if (bus.mshr2Dcache_st_size !== e_size || bus.mshr2Dcache_st_data !== e_sdata) begin bad++; $display("FAIL rnd_st_fields cyc=%0d got=%0d/%h exp=%0d/%h", c, bus.mshr2Dcache_st_size, bus.mshr2Dcache_st_data, e_size, e_sdata); end
                end
            end
            tick();
        end
        $display("test_random: 600 randomized cycles against the reference model");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_coalesce();
        test_store();
        test_retry();
        test_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
